// File: rtl/priority_req_pkg.sv
// Shared types and helpers for the 4-request priority encoder.
package priority_req_pkg;

  typedef enum logic {IDLE, GRANT} prq_state_t;

  localparam int unsigned NUM_REQ = 4;

  // Index of the highest set bit; R3 has top priority. Returns 0 for an empty vector.
  function automatic logic [1:0] highest_idx(input logic [NUM_REQ-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_timeout_counter.sv
// Counts grant cycles; flags expiry when the count reaches TIMEOUT-1.
module grant_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Cycle counter, cleared on reset and on request; never reaches wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/priority_request_encoder_4to2.sv
// Registered 4-request priority encoder with held grant, ACK handshake and timeout.
module priority_request_encoder_4to2 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       R3,
  input  logic       R2,
  input  logic       R1,
  input  logic       R0,
  input  logic       ACK,
  output logic       EN,
  output logic       A1,
  output logic       A0,
  output logic [3:0] PEND,
  output logic       TO
);

  import priority_req_pkg::*;

  prq_state_t state, state_nxt;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] pend_q, pend_nxt;
  logic [1:0]         idx_q, idx_nxt;
  logic               to_q, to_nxt;
  logic               tmr_clr, tmr_inc, tmr_expired;

  assign req = {R3, R2, R1, R0};

  grant_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  // Next state, pending update, index capture and timer control.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    to_nxt    = to_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    pend_nxt  = pend_q;
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (pend_q != '0) begin
          idx_nxt   = highest_idx(pend_q);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ACK) begin
          // Served bit clears first; a same-edge request re-sets it below.
          pend_nxt[idx_q] = 1'b0;
          state_nxt       = IDLE;
        end else if (tmr_expired) begin
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pend_nxt = pend_nxt | req;
  end

  // State, pending, index and timeout registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      pend_q <= '0;
      idx_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      idx_q  <= idx_nxt;
      to_q   <= to_nxt;
    end
  end

  assign EN   = (state == GRANT);
  assign A1   = idx_q[1];
  assign A0   = idx_q[0];
  assign PEND = pend_q;
  assign TO   = to_q;

endmodule

// File: tb/tb_priority_request_encoder_4to2.sv
// Directed bench for priority_request_encoder_4to2 (TIMEOUT = 4).
module tb_priority_request_encoder_4to2;

  import priority_req_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, R3, R2, R1, R0, ACK;
  logic       EN, A1, A0, TO;
  logic [3:0] PEND;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  priority_request_encoder_4to2 #(.TIMEOUT(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .R3   (R3),
    .R2   (R2),
    .R1   (R1),
    .R0   (R0),
    .ACK  (ACK),
    .EN   (EN),
    .A1   (A1),
    .A0   (A0),
    .PEND (PEND),
    .TO   (TO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {R3, R2, R1, R0} = r;
  endtask

  logic [3:0] sim_vec;

  initial begin
    RST = 1'b1; ACK = 1'b0; set_req(4'b1111);
    // Reset with all requests high: requests discarded.
    tick(); tick();
    RST = 1'b0; set_req(4'b0000);
    check("rst_en",   {3'b0, EN}, 4'd0);
    check("rst_a",    {2'b0, A1, A0}, 4'd0);
    check("rst_pend", PEND, 4'b0000);
    check("rst_to",   {3'b0, TO}, 4'd0);

    // ACK while idle is ignored.
    ACK = 1'b1; tick(); ACK = 1'b0;
    check("idle_ack_en",   {3'b0, EN}, 4'd0);
    check("idle_ack_pend", PEND, 4'b0000);

    // Single request R1.
    set_req(4'b0010); tick(); set_req(4'b0000);
    check("s1_pend", PEND, 4'b0010);
    check("s1_en0",  {3'b0, EN}, 4'd0);
    tick();
    check("s1_en",   {3'b0, EN}, 4'd1);
    check("s1_a",    {2'b0, A1, A0}, 4'd1);
    tick(); check("s1_hold1", {3'b0, EN}, 4'd1);
    tick(); check("s1_hold2", {3'b0, EN}, 4'd1);
    ACK = 1'b1; tick(); ACK = 1'b0;
    check("s1_ack_en",   {3'b0, EN}, 4'd0);
    check("s1_ack_pend", PEND, 4'b0000);

    // Simultaneous R3, R2, R0 with ACK always high.
    sim_vec = 4'b1101;
    check("fn_hi", {2'b0, highest_idx(sim_vec)}, 4'd3);
    ACK = 1'b1; set_req(sim_vec); tick(); set_req(4'b0000);
    check("sm_pend", PEND, 4'b1101);
    check("sm_en0",  {3'b0, EN}, 4'd0);
    tick(); check("sm_g3_en", {3'b0, EN}, 4'd1); check("sm_g3_a", {2'b0, A1, A0}, 4'd3);
    tick(); check("sm_i3_en", {3'b0, EN}, 4'd0); check("sm_i3_p", PEND, 4'b0101);
    tick(); check("sm_g2_en", {3'b0, EN}, 4'd1); check("sm_g2_a", {2'b0, A1, A0}, 4'd2);
    tick(); check("sm_i2_en", {3'b0, EN}, 4'd0); check("sm_i2_p", PEND, 4'b0001);
    tick(); check("sm_g0_en", {3'b0, EN}, 4'd1); check("sm_g0_a", {2'b0, A1, A0}, 4'd0);
    tick(); check("sm_i0_en", {3'b0, EN}, 4'd0); check("sm_i0_p", PEND, 4'b0000);
    ACK = 1'b0;

    // Priority hold: R3 arriving mid-grant does not disturb index 0.
    set_req(4'b0001); tick(); set_req(4'b0000);
    tick(); check("ph_en", {3'b0, EN}, 4'd1); check("ph_a", {2'b0, A1, A0}, 4'd0);
    set_req(4'b1000); tick(); set_req(4'b0000);
    check("ph_a1", {2'b0, A1, A0}, 4'd0); check("ph_pend", PEND, 4'b1001);
    tick(); check("ph_a2", {2'b0, A1, A0}, 4'd0); check("ph_en2", {3'b0, EN}, 4'd1);
    ACK = 1'b1; tick(); ACK = 1'b0;
    check("ph_ack_en", {3'b0, EN}, 4'd0); check("ph_ack_p", PEND, 4'b1000);
    tick(); check("ph_g3_en", {3'b0, EN}, 4'd1); check("ph_g3_a", {2'b0, A1, A0}, 4'd3);
    ACK = 1'b1; tick(); ACK = 1'b0;
    check("ph_end_p", PEND, 4'b0000);
    tick(); check("idle_hold_a", {2'b0, A1, A0}, 4'd3); check("idle_hold_en", {3'b0, EN}, 4'd0);

    // Re-request on ACK: R2 held high.
    ACK = 1'b1; set_req(4'b0100); tick();
    check("rr_pend0", PEND, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick(); check("rr_g_en", {3'b0, EN}, 4'd1); check("rr_g_a", {2'b0, A1, A0}, 4'd2);
      tick(); check("rr_i_en", {3'b0, EN}, 4'd0); check("rr_i_p", PEND, 4'b0100);
    end
    set_req(4'b0000);
    tick(); check("rr_last_en", {3'b0, EN}, 4'd1);
    tick(); check("rr_clr_p", PEND, 4'b0000); check("rr_clr_en", {3'b0, EN}, 4'd0);
    ACK = 1'b0;

    // Timeout: EN high exactly 4 cycles, then TO set and PEND kept.
    set_req(4'b0001); tick(); set_req(4'b0000);
    tick(); check("to_en1", {3'b0, EN}, 4'd1); check("to_to0", {3'b0, TO}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("to_en_hold", {3'b0, EN}, 4'd1); check("to_to_hold", {3'b0, TO}, 4'd0);
    end
    tick();
    check("to_drop_en", {3'b0, EN}, 4'd0);
    check("to_flag",    {3'b0, TO}, 4'd1);
    check("to_pend",    PEND, 4'b0001);
    tick(); check("to_regrant", {3'b0, EN}, 4'd1); check("to_rg_a", {2'b0, A1, A0}, 4'd0);
    // Mid-grant reset with a request on the same edge.
    RST = 1'b1; set_req(4'b1000); tick(); RST = 1'b0; set_req(4'b0000);
    check("mr_en",   {3'b0, EN}, 4'd0);
    check("mr_to",   {3'b0, TO}, 4'd0);
    check("mr_pend", PEND, 4'b0000);
    check("mr_a",    {2'b0, A1, A0}, 4'd0);
    tick(); check("mr_idle_en", {3'b0, EN}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/priority_request_encoder_4to2.md
# priority_request_encoder_4to2

Registered 4-request priority encoder with a grant handshake that sits directly upstream of the 2-to-4 priority decoder. It latches request pulses on R3..R0 and selects the highest pending index, R3 first. It then presents that index on A1/A0 with EN as a held grant until the consumer acknowledges it or a timeout expires. Its EN/A1/A0 outputs connect straight to the decoder's EN/A1/A0 inputs.

## Interface
- TIMEOUT, 15: maximum number of cycles a grant is held without ACK; legal range 2..255.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- R3, R2, R1, R0  input  1 each  request lines; any cycle sampled high sets the matching pending bit.
- ACK  input  1  consumer acknowledge; meaningful only while EN=1.
- EN  output  1  grant valid; drives the decoder enable.
- A1, A0  output  1 each  granted index ({A1,A0} = 3 for R3 … 0 for R0); registered.
- PEND  output  4  pending request bits, bit i = Ri.
- TO  output  1  sticky timeout flag; cleared only by RST.

## Operation
- Pending register PEND:
  - Bit i sets on any edge where Ri=1.
  - Bit i clears only on an edge where ACK=1, EN=1, {A1,A0}=i and Ri=0.
  - If Ri=1 on the same edge as that ACK, the bit stays set.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - EN=0.
  - If PEND≠0 at the edge, capture the index of the highest set bit into A1/A0, set EN=1, clear the timer and go to GRANT.
  - If PEND=0, A1/A0 hold their last value.
- GRANT:
  - EN=1; A1/A0 stay stable regardless of new requests, including higher-priority ones.
  - ACK=1 at the edge: clear the served pending bit (per the rule above), EN=0, go to IDLE.
  - ACK=0 and timer=TIMEOUT-1: EN=0, TO=1, pending bit retained, go to IDLE. The request is re-arbitrated later.
  - Otherwise: timer increments.
- Timer width is $clog2(TIMEOUT); it never wraps because it is reset on every entry to GRANT.
- Arbitration is fixed priority, R3 > R2 > R1 > R0, evaluated only in IDLE.
- Reset values: EN=0, A1=0, A0=0, PEND=4'b0000, TO=0, timer=0, state IDLE.

## Timing
- If Ri is high at edge k, PEND[i]=1 after edge k.
- If the FSM is in IDLE, EN=1 with that index after edge k+1, giving 2-cycle request-to-grant latency.
- If ACK is high at edge m (EN=1), EN=0 after edge m.
- The earliest next grant is after edge m+1; at least one IDLE cycle separates grants.
- With no ACK, EN stays high for exactly TIMEOUT cycles, then drops and TO rises on the same edge.
- ACK while EN=0 is ignored; it clears nothing and causes no state change.
- RST high at any edge, including mid-grant, forces all reset values after that edge; requests sampled on that edge are discarded.
- Simultaneous requests: all are latched. They are served in descending index order, one grant each, separated by one IDLE cycle.

## Structure
- Shared package priority_req_pkg holds:
  - typedef enum logic {IDLE, GRANT} prq_state_t
  - localparam NUM_REQ = 4
  - function to compute the highest-set-bit index of a 4-bit vector; the bench reuses it.
- One sub-module, grant_timeout_counter:
  - parameter TIMEOUT
  - inputs CLK, RST, clr, inc
  - output expired, asserted when count==TIMEOUT-1.
- Top level holds PEND, the FSM and the A1/A0/EN registers.

## Test plan
- Reset: assert RST for 2 cycles with R3..R0=4'b1111 -> after release EN=0, A1A0=00, PEND=0000, TO=0.
- Single request: R1 pulsed 1 cycle -> PEND=0010 next cycle; EN=1, A1A0=01 one cycle later. ACK 3 cycles after that -> EN=0, PEND=0000.
- Simultaneous requests: R0,R2,R3 pulsed together, ACK always 1 -> grants 11, 10, 00 in that order, each EN high 1 cycle with one IDLE cycle between.
- Priority hold: grant at index 00 active, R3 pulsed -> A1A0 stays 00 until ACK. Next grant is 11 after one IDLE cycle.
- Re-request on ACK: R2 held high continuously with ACK every grant -> PEND[2] never clears, index 10 re-granted every second cycle.
- Timeout with TIMEOUT=4: R0 pulsed, ACK held 0 -> EN high exactly 4 cycles, then EN=0, TO=1, PEND=0001. Regrant follows; a mid-grant RST clears TO and PEND.
